// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int DW  = 16;
    localparam int OPW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: on a tie the requester not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic sel
);

    assign any = req0 | req1;
    // sel=1 selects requester 1
    assign sel = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/alu_arbiter.sv
// Grants the shared ALU to one of two requesters, latches its operands and
// returns the captured result with a one-cycle done pulse.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [OPW-1:0] opc0,
    input  logic [OPW-1:0] opc1,
    input  logic [DW-1:0]  a0,
    input  logic [DW-1:0]  a1,
    input  logic [DW-1:0]  b0,
    input  logic [DW-1:0]  b1,
    input  logic           cin0,
    input  logic           cin1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [DW-1:0]  res_w,
    output logic           res_zer,
    output logic           res_neg,
    output logic           busy,
    output logic [OPW-1:0] alu_opc,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic           alu_cin,
    input  logic [DW-1:0]  alu_w,
    input  logic           alu_zer,
    input  logic           alu_neg
);

    arb_state_t     r_state;
    arb_state_t     w_next;
    logic           r_last;
    logic           r_owner;
    logic           w_any;
    logic           w_sel;
    logic           w_grant;
    logic [OPW-1:0] r_alu_opc;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic           r_alu_cin;
    logic [DW-1:0]  r_res_w;
    logic           r_res_zer;
    logic           r_res_neg;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (r_last),
        .any  (w_any),
        .sel  (w_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next  = EXEC;
                    w_grant = 1'b1;
                end
            end
            EXEC:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // last starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else if (w_grant) begin
            r_last  <= w_sel;
            r_owner <= w_sel;
        end
    end

    // ALU inputs only move at a grant edge, keeping them glitch-free in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_opc <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cin <= 1'b0;
        end else if (w_grant) begin
            r_alu_opc <= w_sel ? opc1 : opc0;
            r_alu_a   <= w_sel ? a1   : a0;
            r_alu_b   <= w_sel ? b1   : b0;
            r_alu_cin <= w_sel ? cin1 : cin0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_w   <= '0;
            r_res_zer <= 1'b0;
            r_res_neg <= 1'b0;
        end else if (r_state == EXEC) begin
            r_res_w   <= alu_w;
            r_res_zer <= alu_zer;
            r_res_neg <= alu_neg;
        end
    end

    assign gnt0    = (r_state != IDLE) & ~r_owner;
    assign gnt1    = (r_state != IDLE) &  r_owner;
    assign done0   = (r_state == DONE) & ~r_owner;
    assign done1   = (r_state == DONE) &  r_owner;
    assign busy    = (r_state != IDLE);
    assign res_w   = r_res_w;
    assign res_zer = r_res_zer;
    assign res_neg = r_res_neg;
    assign alu_opc = r_alu_opc;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_cin = r_alu_cin;

endmodule
